// File: rtl/psram_ctrl.sv
// psram_ctrl: asynchronous-mode controller for a 16-bit CellularRAM (PSRAM).
// Each 32-bit Avalon-MM access is split into two 16-bit PSRAM accesses,
// low halfword first. All pin timing is set by cycle-count parameters.
//
// Ports:
//   CLK, RST_X           system clock, asynchronous active-low reset
//   avm_*                Avalon-MM slave (22-bit word address, 32-bit data)
//   PSRAM_CLK/ADV_N      tied low (asynchronous mode, no burst)
//   PSRAM_CE_N..UB_N     registered active-low strobes
//   PSRAM_ADDR           registered halfword address
//   PSRAM_DATA           bidirectional data, driven only during write phases
module psram_ctrl #(
  parameter int unsigned RD_CYCLES  = 4,
  parameter int unsigned WR_CYCLES  = 4,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic [21:0] avm_address,
  input  logic        avm_read,
  input  logic        avm_write,
  input  logic [31:0] avm_writedata,
  input  logic [3:0]  avm_byteenable,
  output logic        avm_waitrequest,
  output logic [31:0] avm_readdata,
  output logic        avm_readdatavalid,
  output logic        PSRAM_CLK,
  output logic        PSRAM_ADV_N,
  output logic        PSRAM_CE_N,
  output logic        PSRAM_OE_N,
  output logic        PSRAM_WE_N,
  output logic        PSRAM_LB_N,
  output logic        PSRAM_UB_N,
  output logic [22:0] PSRAM_ADDR,
  inout  wire  [15:0] PSRAM_DATA
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] RD_LAST  = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] WR_LAST  = CW'(WR_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LO, GAP, HI, RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, phase_last;
  logic          cmd_wr, wr_nxt;
  logic [21:0]   cmd_addr, addr_nxt;
  logic [31:0]   cmd_wdata, wdata_nxt;
  logic [3:0]    cmd_be, be_nxt;

  logic          ce_nxt, oe_nxt, we_nxt, lb_nxt, ub_nxt, drive_nxt;
  logic          wait_nxt, rdv_nxt;
  logic [22:0]   paddr_nxt;
  logic [15:0]   dout, dout_nxt;
  logic          drive;
  logic          smp_lo, smp_hi;

  assign PSRAM_CLK   = 1'b0;
  assign PSRAM_ADV_N = 1'b0;
  assign PSRAM_DATA  = drive ? dout : 16'hzzzz;

  // Read data is captured on the last cycle of each read phase.
  assign smp_lo = (state == LO) && !cmd_wr && (cnt == RD_LAST);
  assign smp_hi = (state == HI) && !cmd_wr && (cnt == RD_LAST);

  // Next state, command latch and next pin values (pins follow the next state).
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + CW'(1);
    wr_nxt     = cmd_wr;
    addr_nxt   = cmd_addr;
    wdata_nxt  = cmd_wdata;
    be_nxt     = cmd_be;
    phase_last = cmd_wr ? WR_LAST : RD_LAST;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (avm_read || avm_write) begin
          wr_nxt    = avm_write;
          addr_nxt  = avm_address;
          wdata_nxt = avm_writedata;
          be_nxt    = avm_byteenable;
          if (!avm_write)                 state_nxt = LO;
          else if (|avm_byteenable[1:0])  state_nxt = LO;
          else if (|avm_byteenable[3:2])  state_nxt = HI;
          else                            state_nxt = RESP;
        end
      end
      LO: if (cnt == phase_last) begin
        // A write with no high-halfword enables skips GAP and HI.
        if (!cmd_wr || (|cmd_be[3:2])) state_nxt = GAP;
        else                            state_nxt = IDLE;
      end
      GAP:  if (cnt == GAP_LAST) state_nxt = HI;
      HI:   if (cnt == phase_last) state_nxt = cmd_wr ? IDLE : RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (state_nxt != state) cnt_nxt = '0;

    ce_nxt    = 1'b1;
    oe_nxt    = 1'b1;
    we_nxt    = 1'b1;
    lb_nxt    = 1'b1;
    ub_nxt    = 1'b1;
    drive_nxt = 1'b0;
    paddr_nxt = PSRAM_ADDR;
    dout_nxt  = dout;

    if (state_nxt == LO || state_nxt == HI) begin
      ce_nxt    = 1'b0;
      paddr_nxt = {addr_nxt, state_nxt == HI};
      if (wr_nxt) begin
        // WE_N rises on the final cycle to hold address/data one cycle.
        we_nxt    = (cnt_nxt == WR_LAST);
        drive_nxt = 1'b1;
        dout_nxt  = (state_nxt == HI) ? wdata_nxt[31:16] : wdata_nxt[15:0];
        lb_nxt    = (state_nxt == HI) ? ~be_nxt[2] : ~be_nxt[0];
        ub_nxt    = (state_nxt == HI) ? ~be_nxt[3] : ~be_nxt[1];
      end else begin
        oe_nxt = 1'b0;
        lb_nxt = 1'b0;
        ub_nxt = 1'b0;
      end
    end

    wait_nxt = (state_nxt != IDLE);
    rdv_nxt  = (state_nxt == RESP) && !wr_nxt;
  end

  // State, command and registered pin outputs.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state             <= IDLE;
      cnt               <= '0;
      cmd_wr            <= 1'b0;
      cmd_addr          <= '0;
      cmd_wdata         <= '0;
      cmd_be            <= '0;
      PSRAM_CE_N        <= 1'b1;
      PSRAM_OE_N        <= 1'b1;
      PSRAM_WE_N        <= 1'b1;
      PSRAM_LB_N        <= 1'b1;
      PSRAM_UB_N        <= 1'b1;
      PSRAM_ADDR        <= '0;
      dout              <= '0;
      drive             <= 1'b0;
      avm_waitrequest   <= 1'b0;
      avm_readdatavalid <= 1'b0;
      avm_readdata      <= '0;
    end else begin
      state             <= state_nxt;
      cnt               <= cnt_nxt;
      cmd_wr            <= wr_nxt;
      cmd_addr          <= addr_nxt;
      cmd_wdata         <= wdata_nxt;
      cmd_be            <= be_nxt;
      PSRAM_CE_N        <= ce_nxt;
      PSRAM_OE_N        <= oe_nxt;
      PSRAM_WE_N        <= we_nxt;
      PSRAM_LB_N        <= lb_nxt;
      PSRAM_UB_N        <= ub_nxt;
      PSRAM_ADDR        <= paddr_nxt;
      dout              <= dout_nxt;
      drive             <= drive_nxt;
      avm_waitrequest   <= wait_nxt;
      avm_readdatavalid <= rdv_nxt;
      if (smp_lo) avm_readdata[15:0]  <= PSRAM_DATA;
      if (smp_hi) avm_readdata[31:16] <= PSRAM_DATA;
    end
  end

endmodule
